// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the PISO serial transmitter.
// PISO_PARITY_EN adds one even-parity bit after the LSB of every frame.
package piso_tx_pkg;

  typedef enum logic {IDLE, SHIFT} tx_state_t;

`ifdef PISO_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Wide enough to index every frame bit, including an optional parity bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned frame_len(input int unsigned width);
    return width + ParityBits;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module piso_bit_counter #(
  parameter int unsigned Width    = 4,
  parameter int unsigned MaxCount = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  assign tc_o    = (count_q == Width'(MaxCount));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_left_shift_tx.sv
// MSB-first parallel-in serial-out transmitter with valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_left_shift_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FrameLen = frame_len(WIDTH);
  localparam int unsigned CntW     = cnt_width(WIDTH);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CntW-1:0]  bit_cnt;
  logic             last_bit;
  logic             last_data_bit;
  logic             cnt_clr, cnt_en;
  logic             accept;
  logic             tail_bit;

  piso_bit_counter #(
    .Width    (CntW),
    .MaxCount (FrameLen - 1)
  ) u_bit_counter (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (bit_cnt),
    .tc_o    (last_bit)
  );

  // Counter tracks the index of the bit currently driven on q.
  assign last_data_bit = (bit_cnt == CntW'(WIDTH - 1));
  assign load_ready    = (state_q == IDLE) || last_bit;
  assign accept        = load_valid && load_ready;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = accept ? ^load_data : parity_q;
  assign tail_bit = parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  // Unreachable without parity: the LSB is already the terminal count.
  assign tail_bit = IDLE_BIT;
`endif

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    q_d           = IDLE_BIT;
    q_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = {load_data[WIDTH-2:0], IDLE_BIT};
      q_d           = load_data[WIDTH-1];
      q_valid_d     = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
      done_d        = (state_q == SHIFT);
      cnt_clr       = 1'b1;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        shreg_d = {WIDTH{IDLE_BIT}};
        done_d  = 1'b1;
      end else begin
        shreg_d   = {shreg_q[WIDTH-2:0], IDLE_BIT};
        q_d       = last_data_bit ? tail_bit : shreg_q[WIDTH-1];
        q_valid_d = 1'b1;
        busy_d    = 1'b1;
        cnt_en    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= {WIDTH{IDLE_BIT}};
      q_q           <= IDLE_BIT;
      q_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      q_q           <= q_d;
      q_valid_q     <= q_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign q           = q_q;
  assign q_valid     = q_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
